// File: rtl/l2_pkg.sv
// l2_pkg: shared types and defaults for the L2 tag lookup/replacement controller.
//   - L2_TAG_BITS / L2_INDEX_WIDTH / L2_OFFSET_BITS : default address field widths
//   - l2_state_e    : controller FSM state encoding
//   - l2_addr_split : splits a byte address into tag / index / offset fields
package l2_pkg;

  localparam int L2_TAG_BITS    = 18;
  localparam int L2_INDEX_WIDTH = 9;
  localparam int L2_OFFSET_BITS = 5;
  localparam int L2_ADDR_W      = L2_TAG_BITS + L2_INDEX_WIDTH + L2_OFFSET_BITS;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOOKUP    = 4'd1,
    ST_COMPARE   = 4'd2,
    ST_WB_REQ    = 4'd3,
    ST_WB_WAIT   = 4'd4,
    ST_FILL_REQ  = 4'd5,
    ST_FILL_WAIT = 4'd6,
    ST_INSTALL   = 4'd7,
    ST_RESP      = 4'd8
  } l2_state_e;

  typedef struct packed {
    logic [L2_TAG_BITS-1:0]    tag;
    logic [L2_INDEX_WIDTH-1:0] index;
    logic [L2_OFFSET_BITS-1:0] offset;
  } l2_addr_t;

  // Field split for the default geometry.
  function automatic l2_addr_t l2_addr_split(input logic [L2_ADDR_W-1:0] addr);
    l2_addr_t f;
    f.tag    = addr[L2_ADDR_W-1 -: L2_TAG_BITS];
    f.index  = addr[L2_OFFSET_BITS +: L2_INDEX_WIDTH];
    f.offset = addr[L2_OFFSET_BITS-1:0];
    return f;
  endfunction

endpackage

// File: rtl/l2_tag_cmp.sv
// l2_tag_cmp: combinational hit compare and victim-dirty decode for one
// direct-mapped tag entry.
//   tag_q / tag_valid_r / tag_dirty_r : entry read from the tag array
//   req_tag                           : tag of the request being looked up
//   hit                               : entry valid and tag matches
//   victim_dirty                      : entry holds a valid dirty line that
//                                       must be written back before replacement
module l2_tag_cmp #(
  parameter int TAG_BITS = 18
) (
  input  logic [TAG_BITS-1:0] tag_q,
  input  logic                tag_valid_r,
  input  logic                tag_dirty_r,
  input  logic [TAG_BITS-1:0] req_tag,
  output logic                hit,
  output logic                victim_dirty
);

  assign hit          = tag_valid_r & (tag_q == req_tag);
  // Only consulted on a miss, so a matching tag never reaches write-back.
  assign victim_dirty = tag_valid_r & tag_dirty_r;

endmodule

// File: rtl/l2_tag_ctrl.sv
// l2_tag_ctrl: L2 lookup/replacement controller driving port A of the tag array.
// Accepts one request at a time, reads the indexed tag, decides hit/miss, and on
// a miss sequences an optional dirty write-back and a line fill through the
// memory request channel before installing the new tag entry.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_addr/req_write   request channel
//   resp_valid/resp_ready/resp_hit     response channel
//   mem_req_valid/mem_req_ready/mem_req_wb/mem_req_addr, mem_done   memory side
//   tag_addr/tag_we/tag_wdata/tag_valid_w/tag_dirty_w   tag array port A write/addr
//   tag_q/tag_valid_r/tag_dirty_r      tag array port A read data (1-cycle latency)
//   dbg_state                          current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a producer holds valid and its payload stable until that edge, and
// ready never depends combinationally on the matching valid.
module l2_tag_ctrl
  import l2_pkg::*;
#(
  parameter int TAG_BITS    = L2_TAG_BITS,
  parameter int INDEX_WIDTH = L2_INDEX_WIDTH,
  parameter int OFFSET_BITS = L2_OFFSET_BITS,
  parameter int ADDR_W      = TAG_BITS + INDEX_WIDTH + OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_write,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_wb,
  output logic [ADDR_W-1:0]      mem_req_addr,
  input  logic                   mem_done,
  output logic [INDEX_WIDTH-1:0] tag_addr,
  output logic                   tag_we,
  output logic [TAG_BITS-1:0]    tag_wdata,
  output logic                   tag_valid_w,
  output logic                   tag_dirty_w,
  input  logic [TAG_BITS-1:0]    tag_q,
  input  logic                   tag_valid_r,
  input  logic                   tag_dirty_r,
  output logic [3:0]             dbg_state
);

  l2_state_e state, state_nxt;

  logic                   ready_en;   // low through reset, high from the first edge after release
  logic [TAG_BITS-1:0]    req_tag_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   write_q;
  logic [TAG_BITS-1:0]    victim_q;
  logic                   hit_q;

  logic hit;
  logic victim_dirty;

  // Offset bits select a byte within the line and do not affect the tag path.
  logic unused_offset;
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];

  assign dbg_state = state;

  l2_tag_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
    .tag_q        (tag_q),
    .tag_valid_r  (tag_valid_r),
    .tag_dirty_r  (tag_dirty_r),
    .req_tag      (req_tag_q),
    .hit          (hit),
    .victim_dirty (victim_dirty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (req_valid && req_ready) state_nxt = ST_LOOKUP;
      ST_LOOKUP:    state_nxt = ST_COMPARE;
      ST_COMPARE: begin
        if (hit)               state_nxt = ST_RESP;
        else if (victim_dirty) state_nxt = ST_WB_REQ;
        else                   state_nxt = ST_FILL_REQ;
      end
      ST_WB_REQ:    if (mem_req_ready) state_nxt = ST_WB_WAIT;
      // mem_done only counts once the request has been handed over, so a pulse
      // coincident with the handshake is seen in *_REQ and ignored.
      ST_WB_WAIT:   if (mem_done)      state_nxt = ST_FILL_REQ;
      ST_FILL_REQ:  if (mem_req_ready) state_nxt = ST_FILL_WAIT;
      ST_FILL_WAIT: if (mem_done)      state_nxt = ST_INSTALL;
      ST_INSTALL:   state_nxt = ST_RESP;
      ST_RESP:      if (resp_ready)    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      req_tag_q <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      victim_q  <= '0;
      hit_q     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (state == ST_IDLE && req_valid && req_ready) begin
        req_tag_q <= req_addr[ADDR_W-1 -: TAG_BITS];
        idx_q     <= req_addr[OFFSET_BITS +: INDEX_WIDTH];
        write_q   <= req_write;
      end
      if (state == ST_COMPARE) begin
        hit_q    <= hit;
        victim_q <= tag_q;
      end
    end
  end

  // Output decode: state plus latched registers, with the store-hit write
  // qualified by the tag read data that is valid in COMPARE.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wb    = 1'b0;
    mem_req_addr  = '0;
    tag_addr      = '0;
    tag_we        = 1'b0;
    tag_wdata     = '0;
    tag_valid_w   = 1'b0;
    tag_dirty_w   = 1'b0;

    if (state != ST_IDLE) tag_addr = idx_q;

    case (state)
      ST_IDLE: req_ready = ready_en;
      ST_COMPARE: begin
        if (hit && write_q) begin
          tag_we      = 1'b1;
          tag_wdata   = req_tag_q;
          tag_valid_w = 1'b1;
          tag_dirty_w = 1'b1;
        end
      end
      ST_WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_wb    = 1'b1;
        mem_req_addr  = {victim_q, idx_q, {OFFSET_BITS{1'b0}}};
      end
      ST_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag_q, idx_q, {OFFSET_BITS{1'b0}}};
      end
      ST_INSTALL: begin
        tag_we      = 1'b1;
        tag_wdata   = req_tag_q;
        tag_valid_w = 1'b1;
        tag_dirty_w = write_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
      end
      default: ;
    endcase
  end

endmodule
